// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RV32 funct3 load/store codes, access sizes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Valid/ready data bus between the load/store unit (master) and memory (slave).
interface lsu_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension,
// illegal-funct3 and misalignment detection.
import lsu_pkg::*;

module lsu_align (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misaligned
);

  function automatic logic [31:0] extend(input logic [15:0] v, input lsu_size_e sz,
                                         input logic uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = v[7:0];
    h_s = v;
    if (sz == SZ_B) return uns ? {24'b0, v[7:0]} : 32'(b_s);
    return uns ? {16'b0, v} : 32'(h_s);
  endfunction

  lsu_size_e   size;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign size   = f3_size(funct3);
  assign lane_b = rdata_word[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = write;
      default:          illegal = 1'b1;
    endcase
  end

  // Halves ignore addr[0] and words ignore addr[1:0]; misaligned only reports it.
  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata_word;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = extend({8'b0, lane_b}, SZ_B, funct3[2]);
      end
      SZ_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = extend(lane_h, SZ_H, funct3[2]);
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one valid/ready bus access per request, stalling the core until done.
// Build option: LSU_MISALIGN_TRAP_EN rejects misaligned halves/words with err instead of aligning.
import lsu_pkg::*;

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        err,
  lsu_if.master       bus
);

  localparam int          CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [31:0] TO_LIM = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic        we_p0;
  logic [2:0]  f3_p0;
  logic [31:0] addr_p0, wdata_p0, rdata_p1;
  logic        err_q;
  logic [CW-1:0] cnt_q;

  logic        in_idle, accept, reject, to_hit, abort;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_illegal, al_misaligned;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle & req_valid;

  // While idle the lane logic judges the incoming request; afterwards it serves the latched one.
  lsu_align u_align (
    .write      (in_idle ? req_write : we_p0),
    .funct3     (in_idle ? funct3 : f3_p0),
    .addr_lo    (in_idle ? addr[1:0] : addr_p0[1:0]),
    .wdata      (wdata_p0),
    .rdata_word (bus.bus_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign reject = al_illegal | al_misaligned;
`else
  logic misaligned_unused;
  assign misaligned_unused = al_misaligned;
  assign reject            = al_illegal;
`endif

  assign to_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) >= TO_LIM);
  assign abort  = to_hit & (((state_q == REQ) & ~bus.bus_ready) |
                            ((state_q == RESP) & ~bus.bus_rvalid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = reject ? DONE : REQ;
      REQ:     if (bus.bus_ready) state_d = RESP;
               else if (abort) state_d = DONE;
      RESP:    if (bus.bus_rvalid || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by state so nothing leaks out of unreset data latches.
  always_comb begin
    bus.bus_valid = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_be    = '0;
    bus.bus_wdata = '0;
    done          = 1'b0;
    err           = 1'b0;
    rdata_out     = '0;
    if (state_q == REQ) begin
      bus.bus_valid = 1'b1;
      bus.bus_we    = we_p0;
      bus.bus_addr  = {addr_p0[31:2], 2'b00};
      bus.bus_be    = al_be;
      bus.bus_wdata = al_wdata;
    end
    if (state_q == DONE) begin
      done      = 1'b1;
      err       = err_q;
      rdata_out = rdata_p1;
    end
  end

  assign stall = req_valid & ~done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= reject;
    else if (abort)  err_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt_q <= '0;
    else if (state_q == REQ || state_q == RESP) cnt_q <= cnt_q + 1'b1;
    else                                        cnt_q <= '0;
  end

  // p0: request latch at accept; p1: formatted load data captured with the response.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_write;
      f3_p0    <= funct3;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
    if (accept)
      rdata_p1 <= '0;
    else if (state_q == RESP && bus.bus_rvalid && !we_p0)
      rdata_p1 <= al_rdata;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses vs. a reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int TO_SMALL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_valid2, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err, stall2, done2, err2;
  logic [31:0] rdata_out, rdata_out2;

  lsu_if bus ();
  lsu_if bus2 ();

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata_out(rdata_out), .err(err), .bus(bus)
  );

  load_store_unit #(.TIMEOUT_CYCLES(TO_SMALL)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_write(req_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall2), .done(done2),
    .rdata_out(rdata_out2), .err(err2), .bus(bus2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          o_cyc;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_err, o_we, o_seen, o_stable, o_stall_ok, o_done_after;

  // Reference: access described as (size in bytes, byte offset), not as lane-enable logic.
  function automatic void ref_model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [31:0] rd,
                                    output bit e_err, output logic [31:0] e_addr,
                                    output logic [3:0] e_be, output logic [31:0] e_wd,
                                    output logic [31:0] e_rd);
    int nbytes, off;
    bit legal, mis;
    logic [31:0] mask, raw;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal  = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    off    = int'(a[1:0]);
    mis    = (off % nbytes) != 0;
    off    = off - (off % nbytes);
    e_err  = !legal || (TRAP && mis);
    e_addr = a & 32'hFFFF_FFFC;
    e_be   = 4'(((1 << nbytes) - 1) << off);
    e_wd   = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    raw    = (rd >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 4 && raw[8 * nbytes - 1]) raw = raw | ~mask;
    e_rd   = (w || e_err) ? 32'd0 : raw;
  endfunction

  // Drives one request and plays the bus slave: ready after rwait REQ cycles, rvalid after vwait RESP cycles.
  task automatic do_access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int rwait, input int vwait, input bit keep);
    bit hs;
    int reqc, respc;
    req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    o_cyc = -1; o_seen = 1'b0; o_stable = 1'b1; o_stall_ok = 1'b1;
    o_rdata = 'x; o_err = 1'bx; o_addr = 'x; o_be = 'x; o_wdata = 'x; o_we = 1'bx;
    hs = 1'b0; reqc = 0; respc = 0;
    #1;
    if (stall !== 1'b1) o_stall_ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h5A5A_5A5A;
      if (done) begin
        o_cyc = k; o_rdata = rdata_out; o_err = err;
        if (stall !== 1'b0) o_stall_ok = 1'b0;
        if (!keep) req_valid = 1'b0;
        break;
      end
      if (stall !== 1'b1) o_stall_ok = 1'b0;
      if (hs) begin
        if (bus.bus_valid) o_stable = 1'b0;
        if (respc == vwait) begin bus.bus_rvalid = 1'b1; bus.bus_rdata = rd; end
        respc++;
      end else if (bus.bus_valid) begin
        if (!o_seen) begin
          o_addr = bus.bus_addr; o_be = bus.bus_be; o_wdata = bus.bus_wdata; o_we = bus.bus_we;
        end else if (o_addr !== bus.bus_addr || o_be !== bus.bus_be ||
                     o_wdata !== bus.bus_wdata || o_we !== bus.bus_we) begin
          o_stable = 1'b0;
        end
        o_seen = 1'b1;
        if (reqc == rwait) begin bus.bus_ready = 1'b1; hs = 1'b1; end
        reqc++;
      end
    end
    @(posedge clk); #1;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    o_done_after = done;
    if (o_cyc < 0) begin
      req_valid = 1'b0; rst_n = 1'b0; #1; rst_n = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    funct3 = 3'b0; addr = '0; wdata = '0;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    bus2.bus_ready = 1'b0; bus2.bus_rvalid = 1'b0; bus2.bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({done, err, stall, bus.bus_valid, bus.bus_we, bus.bus_be} !== 9'b0)
      $display("FAIL reset_ctrl got %b want 0", {done, err, stall, bus.bus_valid, bus.bus_we, bus.bus_be});
    else n_pass++;
    n_checks++;
    if ({rdata_out, bus.bus_addr, bus.bus_wdata} !== 96'b0)
      $display("FAIL reset_data got %h want 0", {rdata_out, bus.bus_addr, bus.bus_wdata});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({done, bus.bus_valid} !== 2'b0) $display("FAIL idle_after_reset got %b want 00", {done, bus.bus_valid});
    else n_pass++;
  endtask

  task automatic test_lw;
    do_access(1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    n_checks++; if (o_cyc !== 3) $display("FAIL lw_latency got %0d want 3", o_cyc); else n_pass++;
    n_checks++; if (o_be !== 4'b1111) $display("FAIL lw_be got %b want 1111", o_be); else n_pass++;
    n_checks++; if (o_addr !== 32'h100) $display("FAIL lw_addr got %h want 00000100", o_addr); else n_pass++;
    n_checks++; if (o_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %h want deadbeef", o_rdata); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL lw_err got %b want 0", o_err); else n_pass++;
    n_checks++; if (o_done_after !== 1'b0) $display("FAIL lw_done_pulse got %b want 0", o_done_after); else n_pass++;
    n_checks++; if (o_stall_ok !== 1'b1) $display("FAIL lw_stall got %b want 1", o_stall_ok); else n_pass++;
  endtask

  task automatic test_lb_lbu;
    do_access(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    n_checks++; if (o_addr !== 32'h100) $display("FAIL lb_addr got %h want 00000100", o_addr); else n_pass++;
    n_checks++; if (o_be !== 4'b1000) $display("FAIL lb_be got %b want 1000", o_be); else n_pass++;
    n_checks++; if (o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got %h want ffffff80", o_rdata); else n_pass++;
    do_access(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    n_checks++; if (o_rdata !== 32'h0000_0080) $display("FAIL lbu_rdata got %h want 00000080", o_rdata); else n_pass++;
  endtask

  task automatic test_sh;
    do_access(1'b1, F3_H, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1'b0);
    n_checks++; if (o_be !== 4'b1100) $display("FAIL sh_be got %b want 1100", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); else n_pass++;
    n_checks++; if (o_we !== 1'b1) $display("FAIL sh_we got %b want 1", o_we); else n_pass++;
    n_checks++; if (o_rdata !== 32'h0) $display("FAIL sh_rdata got %h want 0", o_rdata); else n_pass++;
  endtask

  task automatic test_ready_wait;
    do_access(1'b0, F3_W, 32'h300, 32'h0, 32'h0BAD_F00D, 5, 0, 1'b0);
    n_checks++; if (o_cyc !== 8) $display("FAIL wait_latency got %0d want 8", o_cyc); else n_pass++;
    n_checks++; if (o_stable !== 1'b1) $display("FAIL wait_bus_stable got %b want 1", o_stable); else n_pass++;
    n_checks++; if (o_stall_ok !== 1'b1) $display("FAIL wait_stall got %b want 1", o_stall_ok); else n_pass++;
    n_checks++; if (o_rdata !== 32'h0BAD_F00D) $display("FAIL wait_rdata got %h want 0badf00d", o_rdata); else n_pass++;
  endtask

  task automatic test_misalign_illegal;
    do_access(1'b0, F3_W, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 1'b0);
    if (TRAP) begin
      n_checks++; if (o_seen !== 1'b0) $display("FAIL mis_lw_bus got %b want 0", o_seen); else n_pass++;
      n_checks++; if (o_cyc !== 1 || o_err !== 1'b1) $display("FAIL mis_lw_trap got cyc=%0d err=%b want 1/1", o_cyc, o_err); else n_pass++;
      n_checks++; if (o_rdata !== 32'h0) $display("FAIL mis_lw_rdata got %h want 0", o_rdata); else n_pass++;
    end else begin
      n_checks++; if (o_addr !== 32'h100) $display("FAIL mis_lw_addr got %h want 00000100", o_addr); else n_pass++;
      n_checks++; if (o_err !== 1'b0) $display("FAIL mis_lw_err got %b want 0", o_err); else n_pass++;
      n_checks++; if (o_rdata !== 32'h1122_3344) $display("FAIL mis_lw_rdata got %h want 11223344", o_rdata); else n_pass++;
      do_access(1'b0, F3_H, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
      n_checks++; if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF_80FF)
        $display("FAIL mis_lh got be=%b rdata=%h want 1100/ffff80ff", o_be, o_rdata); else n_pass++;
    end
    do_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_seen !== 1'b0 || o_cyc !== 1 || o_err !== 1'b1)
      $display("FAIL illegal_load got bus=%b cyc=%0d err=%b want 0/1/1", o_seen, o_cyc, o_err); else n_pass++;
    do_access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_seen !== 1'b0 || o_cyc !== 1 || o_err !== 1'b1)
      $display("FAIL illegal_store got bus=%b cyc=%0d err=%b want 0/1/1", o_seen, o_cyc, o_err); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_access(1'b0, F3_W, 32'h500, 32'h0, 32'h1111_2222, 0, 0, 1'b1);
    // req_valid still high: the DONE cycle must not have accepted it, so still idle here.
    n_checks++; if (bus.bus_valid !== 1'b0) $display("FAIL b2b_done_ignored got %b want 0", bus.bus_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.bus_valid !== 1'b1 || bus.bus_addr !== 32'h500)
      $display("FAIL b2b_second_req got v=%b a=%h want 1/00000500", bus.bus_valid, bus.bus_addr); else n_pass++;
    bus.bus_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h3333_4444;
    @(posedge clk); #1;
    bus.bus_rvalid = 1'b0;
    n_checks++; if (done !== 1'b1 || rdata_out !== 32'h3333_4444)
      $display("FAIL b2b_second_done got d=%b r=%h want 1/33334444", done, rdata_out); else n_pass++;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int  k;
    bit  bv_ok;
    bit  quiet;
    funct3 = F3_W; addr = 32'h100; req_write = 1'b0; req_valid2 = 1'b1;
    bus2.bus_ready = 1'b0; bus2.bus_rvalid = 1'b0;
    k = -1; bv_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done2) begin k = i; break; end
      if (bus2.bus_valid !== 1'b1) bv_ok = 1'b0;
    end
    n_checks++; if (k !== TO_SMALL + 1) $display("FAIL to_req_latency got %0d want %0d", k, TO_SMALL + 1); else n_pass++;
    n_checks++; if (err2 !== 1'b1 || rdata_out2 !== 32'h0)
      $display("FAIL to_req_err got err=%b r=%h want 1/0", err2, rdata_out2); else n_pass++;
    n_checks++; if (bv_ok !== 1'b1 || bus2.bus_valid !== 1'b0)
      $display("FAIL to_bus_valid got held=%b at_done=%b want 1/0", bv_ok, bus2.bus_valid); else n_pass++;
    req_valid2 = 1'b0;
    @(posedge clk); #1;
    bus2.bus_rvalid = 1'b1; bus2.bus_rdata = 32'hCAFE_CAFE;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done2 !== 1'b0 || bus2.bus_valid !== 1'b0) quiet = 1'b0;
    end
    bus2.bus_rvalid = 1'b0;
    n_checks++; if (quiet !== 1'b1) $display("FAIL to_late_rvalid got quiet=%b want 1", quiet); else n_pass++;
    // Accepted by the bus, but the response never comes.
    req_valid2 = 1'b1; k = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus2.bus_ready = (i == 1);
      if (done2) begin k = i; break; end
    end
    bus2.bus_ready = 1'b0; req_valid2 = 1'b0;
    n_checks++; if (k !== TO_SMALL + 1 || err2 !== 1'b1)
      $display("FAIL to_resp got cyc=%0d err=%b want %0d/1", k, err2, TO_SMALL + 1); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bit quiet;
    req_valid = 1'b1; req_write = 1'b0; funct3 = F3_W; addr = 32'h400;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.bus_valid !== 1'b1) $display("FAIL rstmid_in_req got %b want 1", bus.bus_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.bus_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_immediate got v=%b d=%b want 0/0", bus.bus_valid, done); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hBEEF_0000;
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || bus.bus_valid !== 1'b0) quiet = 1'b0;
    end
    bus.bus_rvalid = 1'b0;
    n_checks++; if (quiet !== 1'b1) $display("FAIL rstmid_stale_rvalid got quiet=%b want 1", quiet); else n_pass++;
    do_access(1'b0, F3_HU, 32'h402, 32'h0, 32'h9876_5432, 1, 1, 1'b0);
    n_checks++; if (o_cyc !== 5 || o_rdata !== 32'h0000_9876)
      $display("FAIL rstmid_recover got cyc=%0d r=%h want 5/00009876", o_cyc, o_rdata); else n_pass++;
  endtask

  task automatic test_random;
    bit          w, e_err;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd, e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    int          rw, vw, e_cyc;
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom; wd = $urandom; rd = $urandom;
      rw = $urandom_range(0, 3); vw = $urandom_range(0, 3);
      ref_model(w, f3, a, wd, rd, e_err, e_addr, e_be, e_wd, e_rd);
      e_cyc = e_err ? 1 : 3 + rw + vw;
      do_access(w, f3, a, wd, rd, rw, vw, 1'b0);
      n_checks++; if (o_cyc !== e_cyc || o_err !== e_err)
        $display("FAIL rnd%0d_done got cyc=%0d err=%b want %0d/%b", i, o_cyc, o_err, e_cyc, e_err); else n_pass++;
      n_checks++; if (o_rdata !== e_rd)
        $display("FAIL rnd%0d_rdata got %h want %h (w=%b f3=%0d a=%h)", i, o_rdata, e_rd, w, f3, a); else n_pass++;
      n_checks++; if (o_seen !== !e_err || o_stable !== 1'b1 || o_stall_ok !== 1'b1)
        $display("FAIL rnd%0d_bus got seen=%b stable=%b stall=%b want %b/1/1", i, o_seen, o_stable, o_stall_ok, !e_err); else n_pass++;
      if (!e_err) begin
        n_checks++; if (o_addr !== e_addr || o_be !== e_be || o_we !== w)
          $display("FAIL rnd%0d_req got a=%h be=%b we=%b want %h/%b/%b", i, o_addr, o_be, o_we, e_addr, e_be, w); else n_pass++;
        if (w) begin
          n_checks++; if (o_wdata !== e_wd)
            $display("FAIL rnd%0d_wdata got %h want %h", i, o_wdata, e_wd); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_ready_wait();
    test_misalign_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
